// File: rtl/q_8_40_pkg.sv
// -----------------------------------------------------------------------------
// q_8_40_pkg
// Shared types and sizes for the q_8_40 serial multiplier output path.
//   BUS_W           : width of the byte bus driven by the multiplier
//   NBYTES          : bytes per product
//   PROD_W          : reassembled product width (BUS_W * NBYTES)
//   collect_state_t : collector FSM state encoding
//   prod_t / byte_t : product word and bus byte types
// -----------------------------------------------------------------------------
package q_8_40_pkg;

  localparam int BUS_W  = 8;
  localparam int NBYTES = 8;
  localparam int PROD_W = BUS_W * NBYTES;
  localparam int CNT_W  = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {
    C_IDLE     = 2'd0,
    C_COLLECT  = 2'd1,
    C_WAIT_LOW = 2'd2
  } collect_state_t;

  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [BUS_W-1:0]  byte_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/q_8_40_prod_collect_if.sv
// -----------------------------------------------------------------------------
// q_8_40_prod_collect_if
// Valid/ready product handshake between the collector and its consumer.
//   prod       : head-of-FIFO product (collector -> consumer)
//   prod_valid : a product is available   (collector -> consumer)
//   prod_ready : consumer accepts prod    (consumer -> collector)
// master = collector side, slave = consumer side.
// -----------------------------------------------------------------------------
interface q_8_40_prod_collect_if;
  import q_8_40_pkg::*;

  prod_t prod;
  logic  prod_valid;
  logic  prod_ready;

  modport master (output prod, output prod_valid, input prod_ready);
  modport slave  (input prod, input prod_valid, output prod_ready);

endinterface

// File: rtl/q_8_40_prod_fifo.sv
// -----------------------------------------------------------------------------
// q_8_40_prod_fifo
// Small pointer-based FIFO with an occupancy count.
//   clk, rst    : clock, asynchronous active-high reset
//   push_i      : write push_data_i (accepted when not full, or full with a pop)
//   push_data_i : word to write
//   pop_i       : remove head entry (ignored when empty)
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
//   head_o      : current head entry
// -----------------------------------------------------------------------------
module q_8_40_prod_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == OCC_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves at the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: storage is reset as well because head_o must read 0 out of reset;
  // this is only affordable because the FIFO is a couple of entries deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

endmodule

// File: rtl/q_8_40_prod_collect.sv
// -----------------------------------------------------------------------------
// q_8_40_prod_collect
// Reassembles the LSB-first byte stream of the q_8_40 serial multiplier into
// 64-bit products, buffers them and offers them on a valid/ready handshake.
//   clk, rst    : clock, asynchronous active-high reset
//   send_output : burst valid, one byte of P per clock while high
//   P           : product byte, least-significant byte first
//   prod_if     : product handshake (prod, prod_valid, prod_ready)
//   busy        : a burst is being collected or its tail is being absorbed
//   err_short   : sticky, burst ended before NBYTES bytes
//   err_long    : sticky, send_output stayed high past NBYTES bytes
//   drop        : sticky, completed product discarded on a full FIFO
//   clr_err     : synchronous clear of the sticky flags (a set event wins)
// -----------------------------------------------------------------------------
module q_8_40_prod_collect
  import q_8_40_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          send_output,
  input  byte_t                         P,
  q_8_40_prod_collect_if.master         prod_if,
  output logic                          busy,
  output logic                          err_short,
  output logic                          err_long,
  output logic                          drop,
  input  logic                          clr_err
);

  collect_state_t state_q, state_d;
  cnt_t           cnt_q, cnt_d;
  prod_t          shift_q, shift_d;
  prod_t          shifted;
  logic           err_short_q, err_short_d;
  logic           err_long_q, err_long_d;
  logic           drop_q, drop_d;
  logic           push, pop, fifo_full, fifo_empty;
  logic           set_short, set_long, set_drop;

  // New bytes enter at the top and move down; after NBYTES shifts the first
  // byte sits in bits [7:0], giving the LSB-first layout directly.
  assign shifted = {P, shift_q[PROD_W-1:BUS_W]};

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    unique case (state_q)
      C_IDLE: begin
        if (send_output) begin
          shift_d = shifted;
          cnt_d   = cnt_t'(1);
          state_d = C_COLLECT;
        end
      end
      C_COLLECT: begin
        if (send_output) begin
          if (cnt_q == cnt_t'(NBYTES - 1)) begin
            // Last byte: the word goes straight from the bus into the FIFO.
            push    = 1'b1;
            shift_d = '0;
            cnt_d   = '0;
            state_d = C_WAIT_LOW;
          end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + 1'b1;
          end
        end else begin
          set_short = 1'b1;
          shift_d   = '0;
          cnt_d     = '0;
          state_d   = C_IDLE;
        end
      end
      C_WAIT_LOW: begin
        // Extra bytes are dropped; a new burst needs a low cycle first.
        if (send_output) set_long = 1'b1;
        else             state_d  = C_IDLE;
      end
      default: begin
        state_d = C_IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  assign pop      = prod_if.prod_valid && prod_if.prod_ready;
  assign set_drop = push && fifo_full && !pop;

  // Set has priority over clear so an event in the clearing cycle is kept.
  assign err_short_d = set_short | (err_short_q & ~clr_err);
  assign err_long_d  = set_long  | (err_long_q  & ~clr_err);
  assign drop_d      = set_drop  | (drop_q      & ~clr_err);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= C_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      drop_q      <= drop_d;
    end
  end

  q_8_40_prod_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PROD_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (shifted),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (prod_if.prod)
  );

  assign prod_if.prod_valid = !fifo_empty;
  assign busy      = (state_q != C_IDLE);
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_q_8_40_prod_collect.sv
// -----------------------------------------------------------------------------
// tb_q_8_40_prod_collect
// Self-checking bench: expected products are queued when a burst that should
// be accepted is driven, and popped when the consumer takes prod.
// -----------------------------------------------------------------------------
module tb_q_8_40_prod_collect;
  import q_8_40_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  send_output;
  byte_t P;
  logic  busy, err_short, err_long, drop, clr_err;

  q_8_40_prod_collect_if prod_if ();

  q_8_40_prod_collect #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .send_output (send_output),
    .P           (P),
    .prod_if     (prod_if),
    .busy        (busy),
    .err_short   (err_short),
    .err_long    (err_long),
    .drop        (drop),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  prod_t sb[$];

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Drives n bytes base, base+step, ... and leaves send_output low afterwards.
  task automatic burst(input int n, input byte_t base, input byte_t step);
    for (int i = 0; i < n; i++) begin
      send_output = 1'b1;
      P = byte_t'(base + byte_t'(i) * step);
      tick();
    end
    send_output = 1'b0;
    P = '0;
  endtask

  // Expected LSB-first word for the byte sequence base, base+step, ...
  function automatic prod_t make_word(input byte_t base, input byte_t step);
    prod_t w;
    for (int k = 0; k < NBYTES; k++) w[k*BUS_W +: BUS_W] = byte_t'(base + byte_t'(k) * step);
    return w;
  endfunction

  function automatic prod_t sb_pop();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; send_output = 1'b0; P = '0; clr_err = 1'b0; prod_if.prod_ready = 1'b0;
    idle(2);
    n_checks++;
    if ({busy, err_short, err_long, drop, prod_if.prod_valid} !== 5'b0) begin
      n_errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, err_short, err_long, drop, prod_if.prod_valid});
    end
    n_checks++;
    if (prod_if.prod !== '0) begin
      n_errors++; $display("FAIL reset_prod: got %h expected 0", prod_if.prod);
    end
    rst = 1'b0;
    idle(2);
    n_checks++;
    if ({busy, err_short, err_long, drop, prod_if.prod_valid} !== 5'b0) begin
      n_errors++; $display("FAIL post_reset_flags: got %b expected 00000", {busy, err_short, err_long, drop, prod_if.prod_valid});
    end
  endtask

  task automatic test_nominal();
    prod_t exp;
    sb.push_back(64'h8877665544332211);
    for (int i = 0; i < NBYTES; i++) begin
      send_output = 1'b1;
      P = byte_t'(8'h11 * (i + 1));
      if (i == NBYTES - 1) begin
        n_checks++;
        if (prod_if.prod_valid !== 1'b0) begin
          n_errors++; $display("FAIL nominal_early_valid: got %b expected 0", prod_if.prod_valid);
        end
      end
      tick();
    end
    send_output = 1'b0; P = '0;
    n_checks++;
    if (prod_if.prod_valid !== 1'b1) begin
      n_errors++; $display("FAIL nominal_valid: got %b expected 1", prod_if.prod_valid);
    end
    exp = sb_pop();
    n_checks++;
    if (prod_if.prod !== exp) begin
      n_errors++; $display("FAIL nominal_prod: got %h expected %h", prod_if.prod, exp);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++; $display("FAIL nominal_busy_wait: got %b expected 1", busy);
    end
    prod_if.prod_ready = 1'b1;
    tick();
    prod_if.prod_ready = 1'b0;
    n_checks++;
    if ({prod_if.prod_valid, busy, err_short, err_long, drop} !== 5'b0) begin
      n_errors++; $display("FAIL nominal_after_pop: got %b expected 00000", {prod_if.prod_valid, busy, err_short, err_long, drop});
    end
  endtask

  task automatic test_short();
    prod_t exp;
    burst(5, 8'h01, 8'h01);
    tick();
    n_checks++;
    if ({err_short, busy, prod_if.prod_valid} !== 3'b100) begin
      n_errors++; $display("FAIL short_flags: got %b expected 100", {err_short, busy, prod_if.prod_valid});
    end
    sb.push_back(64'hAAAAAAAAAAAAAAAA);
    burst(8, 8'hAA, 8'h00);
    exp = sb_pop();
    n_checks++;
    if (prod_if.prod_valid !== 1'b1 || prod_if.prod !== exp) begin
      n_errors++; $display("FAIL short_next_prod: got %b/%h expected 1/%h", prod_if.prod_valid, prod_if.prod, exp);
    end
    n_checks++;
    if (err_short !== 1'b1) begin
      n_errors++; $display("FAIL short_sticky: got %b expected 1", err_short);
    end
    prod_if.prod_ready = 1'b1;
    tick();
    prod_if.prod_ready = 1'b0;
    pulse_clr();
    n_checks++;
    if ({err_short, prod_if.prod_valid} !== 2'b00) begin
      n_errors++; $display("FAIL short_clear: got %b expected 00", {err_short, prod_if.prod_valid});
    end
  endtask

  task automatic test_long();
    prod_t exp;
    sb.push_back(64'h0807060504030201);
    burst(10, 8'h01, 8'h01);
    exp = sb_pop();
    n_checks++;
    if (prod_if.prod_valid !== 1'b1 || prod_if.prod !== exp) begin
      n_errors++; $display("FAIL long_prod: got %b/%h expected 1/%h", prod_if.prod_valid, prod_if.prod, exp);
    end
    n_checks++;
    if ({err_long, err_short, busy} !== 3'b101) begin
      n_errors++; $display("FAIL long_flags: got %b expected 101", {err_long, err_short, busy});
    end
    prod_if.prod_ready = 1'b1;
    tick();
    prod_if.prod_ready = 1'b0;
    n_checks++;
    if ({prod_if.prod_valid, busy} !== 2'b00) begin
      n_errors++; $display("FAIL long_no_extra: got %b expected 00", {prod_if.prod_valid, busy});
    end
    pulse_clr();
    n_checks++;
    if (err_long !== 1'b0) begin
      n_errors++; $display("FAIL long_clear: got %b expected 0", err_long);
    end
  endtask

  task automatic test_fifo_full();
    prod_t exp;
    prod_if.prod_ready = 1'b0;
    sb.push_back(make_word(8'h10, 8'h01)); burst(8, 8'h10, 8'h01); idle(1);
    sb.push_back(make_word(8'h20, 8'h01)); burst(8, 8'h20, 8'h01); idle(1);
    n_checks++;
    if (drop !== 1'b0) begin
      n_errors++; $display("FAIL full_no_drop_yet: got %b expected 0", drop);
    end
    burst(8, 8'h30, 8'h01);
    n_checks++;
    if (drop !== 1'b1) begin
      n_errors++; $display("FAIL full_drop: got %b expected 1", drop);
    end
    idle(1);
    prod_if.prod_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp = sb_pop();
      n_checks++;
      if (prod_if.prod_valid !== 1'b1 || prod_if.prod !== exp) begin
        n_errors++; $display("FAIL full_drain_%0d: got %b/%h expected 1/%h", i, prod_if.prod_valid, prod_if.prod, exp);
      end
      tick();
    end
    prod_if.prod_ready = 1'b0;
    n_checks++;
    if (prod_if.prod_valid !== 1'b0) begin
      n_errors++; $display("FAIL full_empty_after: got %b expected 0", prod_if.prod_valid);
    end
    pulse_clr();
    n_checks++;
    if (drop !== 1'b0) begin
      n_errors++; $display("FAIL full_clear_drop: got %b expected 0", drop);
    end
  endtask

  task automatic test_back_to_back();
    prod_t exp;
    prod_if.prod_ready = 1'b0;
    sb.push_back(make_word(8'h40, 8'h01)); burst(8, 8'h40, 8'h01); idle(1);
    sb.push_back(make_word(8'h50, 8'h01)); burst(8, 8'h50, 8'h01); idle(1);
    burst(7, 8'h60, 8'h01);
    // Last byte of the third burst lands in the same cycle as a pop.
    send_output = 1'b1;
    P = 8'h67;
    prod_if.prod_ready = 1'b1;
    exp = sb_pop();
    n_checks++;
    if (prod_if.prod_valid !== 1'b1 || prod_if.prod !== exp) begin
      n_errors++; $display("FAIL b2b_head: got %b/%h expected 1/%h", prod_if.prod_valid, prod_if.prod, exp);
    end
    sb.push_back(make_word(8'h60, 8'h01));
    tick();
    send_output = 1'b0; P = '0;
    prod_if.prod_ready = 1'b0;
    n_checks++;
    if (drop !== 1'b0) begin
      n_errors++; $display("FAIL b2b_drop: got %b expected 0", drop);
    end
    prod_if.prod_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp = sb_pop();
      n_checks++;
      if (prod_if.prod_valid !== 1'b1 || prod_if.prod !== exp) begin
        n_errors++; $display("FAIL b2b_order_%0d: got %b/%h expected 1/%h", i, prod_if.prod_valid, prod_if.prod, exp);
      end
      tick();
    end
    prod_if.prod_ready = 1'b0;
    n_checks++;
    if (prod_if.prod_valid !== 1'b0) begin
      n_errors++; $display("FAIL b2b_empty_after: got %b expected 0", prod_if.prod_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    prod_t exp;
    prod_if.prod_ready = 1'b0;
    sb.push_back(make_word(8'h70, 8'h01)); burst(8, 8'h70, 8'h01); idle(1);
    for (int i = 0; i < 4; i++) begin
      send_output = 1'b1;
      P = byte_t'(8'hE0 + i);
      tick();
    end
    n_checks++;
    if ({busy, prod_if.prod_valid} !== 2'b11) begin
      n_errors++; $display("FAIL rst_mid_before: got %b expected 11", {busy, prod_if.prod_valid});
    end
    // Reset between clock edges: outputs must clear without waiting for clk.
    rst = 1'b1;
    send_output = 1'b0;
    P = '0;
    #1;
    n_checks++;
    if ({busy, err_short, err_long, drop, prod_if.prod_valid} !== 5'b0 || prod_if.prod !== '0) begin
      n_errors++; $display("FAIL rst_mid_async: got %b/%h expected 00000/0", {busy, err_short, err_long, drop, prod_if.prod_valid}, prod_if.prod);
    end
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    sb.push_back(64'hC8C7C6C5C4C3C2C1);
    burst(8, 8'hC1, 8'h01);
    exp = sb_pop();
    n_checks++;
    if (prod_if.prod_valid !== 1'b1 || prod_if.prod !== exp) begin
      n_errors++; $display("FAIL rst_mid_fresh: got %b/%h expected 1/%h", prod_if.prod_valid, prod_if.prod, exp);
    end
    prod_if.prod_ready = 1'b1;
    tick();
    prod_if.prod_ready = 1'b0;
    n_checks++;
    if (prod_if.prod_valid !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_no_stale: got %b expected 0", prod_if.prod_valid);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short();
    test_long();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid_burst();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++; $display("FAIL scoreboard_left: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
